// File: rtl/latency_pkg.sv
`default_nettype none
// ============================================================================
// Module      : latency_pkg
// Description : Shared definitions for the latency measurement stages.
//               Holds the default count width (shared with the counter stage)
//               and the state encoding of the averaging FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package latency_pkg;

    // Width of the issue / aggregate-latency counts and of the averaged result.
    localparam int LATENCY_W_DEFAULT = 32;

    // Averaging FSM states. ROUND is only reachable when rounding is compiled in.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } latency_avg_state_t;

endpackage
`default_nettype wire

// File: rtl/serial_divider.sv
`default_nettype none
// ============================================================================
// Module      : serial_divider
// Description : Radix-2 restoring divider, one quotient bit per clock.
//               A `load` pulse captures the dividend and starts W iterations.
//               The divisor must be held stable by the caller for the whole
//               division. `valid` pulses in the cycle of the final iteration;
//               `quotient` / `remainder` carry that iteration's result in the
//               same cycle, so the caller registers them on that edge.
// Ports       : clk, rst_n (sync, active-low)
//               load, dividend[W], divisor[W]   -> start a division
//               valid, quotient[W], remainder[W] <- final iteration result
// Note        : W must be at least 2.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_divider
    import latency_pkg::*;
#(
    parameter int W = LATENCY_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         valid,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder
);

    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam logic [CW-1:0] c_cnt_start = CW'(W - 1);
    localparam logic [CW-1:0] c_cnt_one   = CW'(1);

    logic          r_active;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_quo;     // dividend bits shift out of the top, quotient bits in at the bottom
    logic [W-1:0]  r_rem;     // partial remainder, always < divisor between iterations

    logic [W:0]    w_shift;   // W+1 bits so the trial subtraction cannot overflow
    logic [W:0]    w_diff;
    logic          w_fit;
    logic [W-1:0]  w_rem_next;
    logic [W-1:0]  w_quo_next;

    always_comb begin
        w_shift    = {r_rem, r_quo[W-1]};
        w_diff     = w_shift - {1'b0, divisor};
        // A borrow into the top bit means the divisor did not fit.
        w_fit      = ~w_diff[W];
        w_rem_next = w_fit ? w_diff[W-1:0] : w_shift[W-1:0];
        w_quo_next = {r_quo[W-2:0], w_fit};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_quo    <= '0;
            r_rem    <= '0;
        end else if (load) begin
            r_active <= 1'b1;
            r_cnt    <= c_cnt_start;
            r_quo    <= dividend;
            r_rem    <= '0;
        end else if (r_active) begin
            r_quo <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt - c_cnt_one;
            if (r_cnt == '0) begin
                r_active <= 1'b0;
            end
        end
    end

    assign valid     = r_active && (r_cnt == '0);
    assign quotient  = w_quo_next;
    assign remainder = w_rem_next;

endmodule
`default_nettype wire

// File: rtl/latency_avg.sv
`default_nettype none
// ============================================================================
// Module      : latency_avg
// Description : Average latency per issued operation, aggregate / issue.
//               Operands are captured on an accepted `start`, divided by a
//               serial restoring divider, and the result is presented with a
//               one-cycle `done` pulse. A zero divisor short-circuits to DONE
//               with avg=0, rem=0 and div_zero_o=1.
// Config      : LATENCY_AVG_ROUND_EN - when defined, a ROUND state rounds the
//               quotient to nearest (half up, saturating); rem_o keeps the
//               truncated remainder. Latency grows by one cycle.
// Ports       : clk, rst_n (sync, active-low)
//               start, issue_cnt_i[W] (divisor), aggregate_cnt_i[W] (dividend)
//               busy, done, avg_o[W], rem_o[W], div_zero_o
// Revision    : 1.0 - initial release
// ============================================================================
module latency_avg
    import latency_pkg::*;
#(
    parameter int W = LATENCY_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] issue_cnt_i,
    input  logic [W-1:0] aggregate_cnt_i,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] avg_o,
    output logic [W-1:0] rem_o,
    output logic         div_zero_o
);

    latency_avg_state_t r_state;
    latency_avg_state_t w_state_next;

    logic [W-1:0] r_divisor;
    logic [W-1:0] r_avg;
    logic [W-1:0] r_rem;
    logic         r_div_zero;

    logic         w_accept;
    logic         w_zero;
    logic         w_load;
    logic         w_div_valid;
    logic [W-1:0] w_div_quo;
    logic [W-1:0] w_div_rem;

    assign w_accept = start && (r_state == IDLE);
    assign w_zero   = (issue_cnt_i == '0);
    assign w_load   = w_accept && !w_zero;

    serial_divider #(
        .W (W)
    ) u_divider (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_load),
        .dividend  (aggregate_cnt_i),
        .divisor   (r_divisor),
        .valid     (w_div_valid),
        .quotient  (w_div_quo),
        .remainder (w_div_rem)
    );

`ifdef LATENCY_AVG_ROUND_EN
    logic [W-1:0] r_trunc_quo;
    logic [W-1:0] r_trunc_rem;
    logic [W:0]   w_rem_x2;
    logic [W:0]   w_quo_inc;
    logic [W-1:0] w_avg_round;

    // rem < divisor, so 2*rem fits in W+1 bits; q+1 can only carry out when
    // q is all ones, in which case the result saturates.
    always_comb begin
        w_rem_x2    = {r_trunc_rem, 1'b0};
        w_quo_inc   = {1'b0, r_trunc_quo} + {{W{1'b0}}, 1'b1};
        w_avg_round = r_trunc_quo;
        if (w_rem_x2 >= {1'b0, r_divisor}) begin
            w_avg_round = w_quo_inc[W] ? {W{1'b1}} : w_quo_inc[W-1:0];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = w_zero ? DONE : DIV;
                end
            end
            DIV: begin
                if (w_div_valid) begin
`ifdef LATENCY_AVG_ROUND_EN
                    w_state_next = ROUND;
`else
                    w_state_next = DONE;
`endif
                end
            end
`ifdef LATENCY_AVG_ROUND_EN
            ROUND:   w_state_next = DONE;
`endif
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Operand capture and result registers. Results are written on the edge
    // that enters DONE, so they are already valid while `done` is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_divisor   <= '0;
            r_avg       <= '0;
            r_rem       <= '0;
            r_div_zero  <= 1'b0;
`ifdef LATENCY_AVG_ROUND_EN
            r_trunc_quo <= '0;
            r_trunc_rem <= '0;
`endif
        end else begin
            if (w_accept) begin
                r_divisor <= issue_cnt_i;
            end
            if (w_accept && w_zero) begin
                r_avg      <= '0;
                r_rem      <= '0;
                r_div_zero <= 1'b1;
            end
`ifdef LATENCY_AVG_ROUND_EN
            if ((r_state == DIV) && w_div_valid) begin
                r_trunc_quo <= w_div_quo;
                r_trunc_rem <= w_div_rem;
            end
            if (r_state == ROUND) begin
                r_avg      <= w_avg_round;
                r_rem      <= r_trunc_rem;
                r_div_zero <= 1'b0;
            end
`else
            if ((r_state == DIV) && w_div_valid) begin
                r_avg      <= w_div_quo;
                r_rem      <= w_div_rem;
                r_div_zero <= 1'b0;
            end
`endif
        end
    end

    // DONE still counts as busy, so a start coinciding with DONE is dropped.
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign avg_o      = r_avg;
    assign rem_o      = r_rem;
    assign div_zero_o = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_latency_avg.sv
`default_nettype none
// ============================================================================
// Module      : tb_latency_avg
// Description : Self-checking bench for latency_avg. A behavioural model
//               (plain division plus a cycle schedule) predicts busy, done and
//               the result outputs every cycle; directed tests add literal
//               expectations for latency and results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_latency_avg;

    localparam int W = 32;
`ifdef LATENCY_AVG_ROUND_EN
    localparam bit RND = 1'b1;
    localparam int LAT = W + 2;
    localparam logic [W-1:0] E_1005_10 = 32'd101;
    localparam logic [W-1:0] E_3_2     = 32'd2;
    localparam logic [W-1:0] E_5_3     = 32'd2;
    localparam logic [W-1:0] E_FF_2    = 32'h8000_0000;
`else
    localparam bit RND = 1'b0;
    localparam int LAT = W + 1;
    localparam logic [W-1:0] E_1005_10 = 32'd100;
    localparam logic [W-1:0] E_3_2     = 32'd1;
    localparam logic [W-1:0] E_5_3     = 32'd1;
    localparam logic [W-1:0] E_FF_2    = 32'h7FFF_FFFF;
`endif
    localparam longint unsigned MAXV = (64'd1 << W) - 64'd1;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] issue_cnt;
    logic [W-1:0] aggregate_cnt;
    logic         busy;
    logic         done;
    logic [W-1:0] avg;
    logic [W-1:0] rem;
    logic         div_zero;

    int n_checks = 0;
    int n_fail   = 0;

    latency_avg #(
        .W (W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .issue_cnt_i     (issue_cnt),
        .aggregate_cnt_i (aggregate_cnt),
        .busy            (busy),
        .done            (done),
        .avg_o           (avg),
        .rem_o           (rem),
        .div_zero_o      (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint unsigned act, input longint unsigned req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Reference result straight from the arithmetic definition.
    function automatic void model_div(input longint unsigned a, input longint unsigned b,
                                      output logic [W-1:0] q_o, output logic [W-1:0] r_o,
                                      output bit dz_o);
        longint unsigned q;
        longint unsigned r;
        if (b == 0) begin
            q_o  = '0;
            r_o  = '0;
            dz_o = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            if (RND && (2 * r >= b)) begin
                q = (q + 1 > MAXV) ? MAXV : q + 1;
            end
            q_o  = W'(q);
            r_o  = W'(r);
            dz_o = 1'b0;
        end
    endfunction

    // ---------------- cycle model + per-cycle compare -----------------------
    bit           m_armed  = 1'b0;
    bit           m_active = 1'b0;
    int           m_left   = 0;
    bit           prev_busy;
    bit           exp_busy = 1'b0;
    bit           exp_done = 1'b0;
    logic [W-1:0] exp_avg  = '0;
    logic [W-1:0] exp_rem  = '0;
    bit           exp_dz   = 1'b0;
    logic [W-1:0] p_avg;
    logic [W-1:0] p_rem;
    bit           p_dz;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_armed  = 1'b1;
            m_active = 1'b0;
            exp_busy = 1'b0;
            exp_done = 1'b0;
            exp_avg  = '0;
            exp_rem  = '0;
            exp_dz   = 1'b0;
        end else if (m_armed) begin
            prev_busy = exp_busy;
            exp_done  = 1'b0;
            if (m_active) begin
                exp_busy = 1'b1;
                if (m_left == 0) begin
                    exp_avg  = p_avg;
                    exp_rem  = p_rem;
                    exp_dz   = p_dz;
                    exp_done = 1'b1;
                    m_active = 1'b0;
                end else begin
                    m_left--;
                end
            end else if (start && !prev_busy) begin
                model_div(aggregate_cnt, issue_cnt, p_avg, p_rem, p_dz);
                exp_busy = 1'b1;
                if (issue_cnt == '0) begin
                    exp_avg  = p_avg;
                    exp_rem  = p_rem;
                    exp_dz   = p_dz;
                    exp_done = 1'b1;
                end else begin
                    m_active = 1'b1;
                    m_left   = LAT - 2;
                end
            end else begin
                exp_busy = 1'b0;
            end
        end
        #1;
        if (m_armed) begin
            check("model busy", busy, exp_busy);
            check("model done", done, exp_done);
            check("model avg", avg, exp_avg);
            check("model rem", rem, exp_rem);
            check("model div_zero", div_zero, exp_dz);
        end
    end

    // ---------------- directed stimulus -------------------------------------
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] e_avg, input logic [W-1:0] e_rem,
                           input bit e_dz, input int e_lat, input string tag);
        int n;
        @(negedge clk);
        aggregate_cnt = a;
        issue_cnt     = b;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start         = 1'b0;
        aggregate_cnt = W'($urandom);
        issue_cnt     = W'($urandom);
        n = 1;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, e_lat);
        check({tag, " avg"}, avg, e_avg);
        check({tag, " rem"}, rem, e_rem);
        check({tag, " div_zero"}, div_zero, e_dz);
        @(posedge clk);
        #1;
        check({tag, " idle after done"}, busy, 0);
    endtask

    initial begin
        int n;
        int dones;
        rst_n         = 1'b0;
        start         = 1'b0;
        issue_cnt     = '0;
        aggregate_cnt = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset avg", avg, 0);
        check("reset rem", rem, 0);
        check("reset div_zero", div_zero, 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div(32'd1005, 32'd10, E_1005_10, 32'd5, 1'b0, LAT, "1005/10");

        // Reset five cycles into a division: everything clears, no done.
        @(negedge clk);
        aggregate_cnt = 32'd1000;
        issue_cnt     = 32'd10;
        start         = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("midreset busy", busy, 0);
        check("midreset avg", avg, 0);
        check("midreset rem", rem, 0);
        dones = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("midreset no done", dones, 0);
        run_div(32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, LAT, "1000/10 after reset");

        run_div(32'd3, 32'd2, E_3_2, 32'd1, 1'b0, LAT, "3/2");
        run_div(32'd5, 32'd3, E_5_3, 32'd2, 1'b0, LAT, "5/3");
        run_div(32'd7, 32'd0, 32'd0, 32'd0, 1'b1, 1, "7/0");
        run_div(32'd8, 32'd4, 32'd2, 32'd0, 1'b0, LAT, "8/4");

        // start held high throughout a 1000/10 divide with 50/5 on the bus.
        @(negedge clk);
        aggregate_cnt = 32'd1000;
        issue_cnt     = 32'd10;
        start         = 1'b1;
        @(posedge clk);
        #1;
        aggregate_cnt = 32'd50;
        issue_cnt     = 32'd5;
        n = 1;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("spam latency", n, LAT);
        check("spam avg", avg, 32'd100);
        @(posedge clk);
        #1;
        check("spam done single", done, 0);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("spam reaccept busy", busy, 1);
        n = 1;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("spam2 latency", n, LAT);
        check("spam2 avg", avg, 32'd10);
        check("spam2 rem", rem, 32'd0);
        @(posedge clk);

        run_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT, "max/1");
        run_div(32'hFFFF_FFFF, 32'd2, E_FF_2, 32'd1, 1'b0, LAT, "max/2");
        run_div(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, LAT, "0/5");

        repeat (3) @(posedge clk);
        #2;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/latency_avg.md
# latency_avg

Downstream stage of the latency counter. It samples that block's issue count and aggregate-latency count on a `start` pulse and computes the average latency per issued operation, aggregate / issue, with a serial radix-2 restoring divider. It returns quotient and remainder with a one-cycle `done` pulse, and flags divide-by-zero. Software or a perf-monitor sequencer pulses `start` after retiring a measurement window and reads the result once `done` asserts.

## Interface
- `W`, default 32: width of both counts and of the results.
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `start`  in  1  request a new average; accepted only when `busy`=0.
- `issue_cnt_i`  in  W  divisor, taken from the counter's `issue_cnt_r`.
- `aggregate_cnt_i`  in  W  dividend, taken from the counter's `aggregate_cnt_r`.
- `busy`  out  1  high while a division is in flight.
- `done`  out  1  one-cycle pulse; results are valid from this cycle onward.
- `avg_o`  out  W  quotient, rounded when rounding is enabled.
- `rem_o`  out  W  remainder of the truncating divide.
- `div_zero_o`  out  1  the last accepted request had `issue_cnt_i`==0.

## Operation
- States: IDLE, DIV, (ROUND), DONE.
- IDLE:
  - On `start`, both operands are latched into internal registers.
  - The input ports are don't-care after the accept edge.
  - If the latched divisor is 0, go to DONE; otherwise go to DIV with bit counter = W-1.
- DIV:
  - Each cycle: shift the partial remainder left, bringing in the next dividend MSB.
  - If partial remainder ≥ divisor, subtract and set quotient bit 1; otherwise the bit is 0.
  - Use a W+1-bit partial remainder so the subtraction cannot overflow.
  - After W iterations (counter reaches 0), go to ROUND if that state is compiled in, else to DONE.
- ROUND: see Configuration.
- DONE:
  - `avg_o`, `rem_o` and `div_zero_o` update in this state.
  - `done`=1 for exactly one cycle, then return to IDLE.
- Divide-by-zero result: `avg_o`=0, `rem_o`=0, `div_zero_o`=1. Any non-zero divisor clears `div_zero_o`.
- Result outputs hold their value until the next DONE.
- `start` while `busy`=1 is ignored; no queuing, no error flag.
- `start` in the same cycle as DONE is ignored, because `busy` is still high in DONE.

## Timing
- Reset (`rst_n`=0 at an edge), on the following cycle:
  - state = IDLE;
  - `busy`=0, `done`=0, `avg_o`=0, `rem_o`=0, `div_zero_o`=0.
- Reset mid-operation aborts the division. No `done` is produced.
- Normal latency, with `start` sampled at edge T:
  - `busy`=1 during cycles T+1 … T+W+1 (DIV plus DONE);
  - `done`=1 in cycle T+W+1, i.e. W+1 cycles after the accept.
  - ROUND adds one cycle: `done` in cycle T+W+2.
- Zero-divisor latency: `done` in cycle T+1, with `busy`=1 in that cycle only.
- The earliest next accept is the cycle after `done`. Back-to-back throughput is therefore one result per W+2 cycles.
- Outputs are registered. There is no combinational path from any input to any output.

## Configuration
- `LATENCY_AVG_ROUND_EN` defined:
  - the ROUND state is compiled in;
  - `avg_o` = q + 1 when 2·rem ≥ divisor, computed at W+1 bits;
  - `avg_o` saturates at 2^W−1 instead of wrapping;
  - `rem_o` still reports the truncated remainder;
  - latency is W+2.
- `LATENCY_AVG_ROUND_EN` undefined:
  - truncating divide, no ROUND state;
  - latency is W+1.
- The zero-divisor path bypasses ROUND in both builds.

## Structure
- Shared package `latency_pkg` holds:
  - the state enum typedef `latency_avg_state_t` (IDLE, DIV, ROUND, DONE);
  - `LATENCY_W_DEFAULT` = 32, also used by the counter stage.
- One sub-module, `serial_divider`:
  - owns the remainder/quotient shift registers and the bit counter;
  - handshake: `load` in, `valid` pulse out.
- `latency_avg` keeps the FSM, zero detect, rounding and output registers.

## Test plan
- Reset mid-division:
  - start with aggregate=1000, issue=10, then drop `rst_n` 5 cycles later;
  - required: all outputs 0 and no `done`;
  - a fresh start afterwards returns avg=100, rem=0 after 33 cycles (W=32).
- 1005/10:
  - truncating build: avg=100, rem=5;
  - ROUND_EN build: avg=101, rem=5, `done` 34 cycles after accept.
- 3/2 and 5/3 in the ROUND_EN build:
  - 3/2 gives avg=2, rem=1;
  - 5/3 gives avg=2, rem=2;
  - truncating build gives avg=1 for both.
- 7/0:
  - `done` the cycle after accept, `busy` high that single cycle;
  - avg=0, rem=0, `div_zero_o`=1;
  - a following 8/4 clears the flag and returns avg=2.
- `start` pulsed every cycle during a 1000/10 divide, with the operands changed to 50/5 on those cycles:
  - exactly one `done`, with the result 100;
  - the next accepted start, with operands 50/5, returns 10.
- 0xFFFFFFFF/1:
  - returns avg=0xFFFFFFFF, rem=0;
  - ROUND_EN build: 0xFFFFFFFF/2 returns 0x80000000 (2·rem = 2 ≥ 2, so rounds up; no saturation needed).
